// File: rtl/fpu_f2i_if.sv
// rtl/fpu_f2i_if.sv - request/response bundle for the float-to-integer converter
interface fpu_f2i_if;
    logic        start;
    logic        is_unsigned;
    logic [2:0]  rm;
    logic [31:0] operand;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  fflags;

    modport master (
        output start, is_unsigned, rm, operand,
        input  busy, done, result, fflags
    );

    modport slave (
        input  start, is_unsigned, rm, operand,
        output busy, done, result, fflags
    );
endinterface

// File: rtl/fpu_f2i.sv
// rtl/fpu_f2i.sv - multi-cycle binary32 to int32/uint32 converter (FCVT.W.S / FCVT.WU.S)
module fpu_f2i (
    input  logic       clock,
    input  logic       reset_n,
    fpu_f2i_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, PREP, SHIFT, ROUND} state_t;

    state_t      state, state_nx;
    logic [31:0] op_q;
    logic        uns_q;
    logic [2:0]  rm_q;
    logic [31:0] sig;
    logic        guard, sticky;
    logic [4:0]  cnt;
    logic        shl;
    logic        sat, sat_neg;
    logic        done_q;
    logic [31:0] result_q;
    logic [4:0]  fflags_q;

    // Classification of the latched operand, consumed in PREP
    logic [7:0]  e;
    logic [22:0] m;
    logic [31:0] cls_sig;
    logic        cls_sticky, cls_shl, cls_sat, cls_sat_neg;
    logic [7:0]  cls_n8;
    logic [4:0]  cls_n;

    always_comb begin
        e           = op_q[30:23];
        m           = op_q[22:0];
        cls_sig     = 32'd0;
        cls_sticky  = 1'b0;
        cls_shl     = 1'b0;
        cls_sat     = 1'b0;
        cls_sat_neg = 1'b0;
        cls_n8      = 8'd0;
        if (e == 8'd255) begin
            cls_sat     = 1'b1;
            cls_sat_neg = (m == 23'd0) && op_q[31];
        end else if (e == 8'd0 && m == 23'd0) begin
            cls_sig = 32'd0;
        end else if (e <= 8'd125) begin
            cls_sticky = 1'b1;
        end else if (e <= 8'd149) begin
            cls_sig = {8'd0, 1'b1, m};
            cls_n8  = 8'd150 - e;
        end else if (e <= 8'd158) begin
            cls_sig = {8'd0, 1'b1, m};
            cls_n8  = e - 8'd150;
            cls_shl = 1'b1;
        end else begin
            cls_sat     = 1'b1;
            cls_sat_neg = op_q[31];
        end
        cls_n = cls_n8[4:0];
    end

    // Rounding and range check on the shifted magnitude
    logic        neg, inc;
    logic [32:0] mag;
    logic [31:0] res_nx;
    logic [4:0]  fl_nx;
    logic        nx;

    always_comb begin
        neg = op_q[31];
        case (rm_q)
            3'b000:  inc = guard & (sticky | sig[0]);
            3'b010:  inc = neg & (guard | sticky);
            3'b011:  inc = !neg & (guard | sticky);
            3'b100:  inc = guard;
            default: inc = 1'b0;
        endcase
        mag    = {1'b0, sig} + {32'd0, inc};
        nx     = guard | sticky;
        res_nx = 32'd0;
        fl_nx  = 5'd0;
        if (!uns_q) begin
            if (sat) begin
                res_nx = sat_neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
                fl_nx  = 5'h10;
            end else if (!neg && mag > 33'h0_7FFF_FFFF) begin
                res_nx = 32'h7FFF_FFFF;
                fl_nx  = 5'h10;
            end else if (neg && mag > 33'h0_8000_0000) begin
                res_nx = 32'h8000_0000;
                fl_nx  = 5'h10;
            end else begin
                res_nx = neg ? (~mag[31:0] + 32'd1) : mag[31:0];
                fl_nx  = {4'd0, nx};
            end
        end else begin
            if (sat) begin
                res_nx = sat_neg ? 32'd0 : 32'hFFFF_FFFF;
                fl_nx  = 5'h10;
            end else if (!neg && mag[32]) begin
                res_nx = 32'hFFFF_FFFF;
                fl_nx  = 5'h10;
            end else if (neg && mag != 33'd0) begin
                res_nx = 32'd0;
                fl_nx  = 5'h10;
            end else begin
                res_nx = neg ? 32'd0 : mag[31:0];
                fl_nx  = {4'd0, nx};
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start && !done_q) state_nx = PREP;
            PREP:    state_nx = (cls_n == 5'd0) ? ROUND : SHIFT;
            SHIFT:   if (cnt == 5'd1) state_nx = ROUND;
            ROUND:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            op_q     <= 32'd0;
            uns_q    <= 1'b0;
            rm_q     <= 3'd0;
            sig      <= 32'd0;
            guard    <= 1'b0;
            sticky   <= 1'b0;
            cnt      <= 5'd0;
            shl      <= 1'b0;
            sat      <= 1'b0;
            sat_neg  <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 32'd0;
            fflags_q <= 5'd0;
        end else begin
            state  <= state_nx;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !done_q) begin
                        op_q  <= bus.operand;
                        uns_q <= bus.is_unsigned;
                        rm_q  <= bus.rm;
                    end
                end
                PREP: begin
                    sig     <= cls_sig;
                    guard   <= 1'b0;
                    sticky  <= cls_sticky;
                    cnt     <= cls_n;
                    shl     <= cls_shl;
                    sat     <= cls_sat;
                    sat_neg <= cls_sat_neg;
                end
                SHIFT: begin
                    cnt <= cnt - 5'd1;
                    if (shl) begin
                        sig <= {sig[30:0], 1'b0};
                    end else begin
                        sig    <= {1'b0, sig[31:1]};
                        guard  <= sig[0];
                        sticky <= sticky | guard;
                    end
                end
                ROUND: begin
                    result_q <= res_nx;
                    fflags_q <= fl_nx;
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // busy covers the done cycle so a new request lands the cycle after it
    assign bus.busy   = (state != IDLE) || done_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.fflags = fflags_q;
endmodule

// File: tb/tb_fpu_f2i.sv
// tb/tb_fpu_f2i.sv - directed self-checking bench for fpu_f2i
module tb_fpu_f2i;
    logic clock;
    logic reset_n;
    int   checks;
    int   failures;

    fpu_f2i_if bus ();

    fpu_f2i dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic conv(input string tag, input logic [31:0] op, input logic uns,
                        input logic [2:0] r, input logic [31:0] exp_res,
                        input logic [4:0] exp_fl, input int exp_edges);
        int edges;
        @(negedge clock);
        bus.operand     = op;
        bus.is_unsigned = uns;
        bus.rm          = r;
        bus.start       = 1'b1;
        @(posedge clock);
        edges = 0;
        @(negedge clock);
        bus.start = 1'b0;
        chk32({tag, ".busy_accept"}, {31'd0, bus.busy}, 32'd1);
        while (!bus.done && edges < 60) begin
            @(posedge clock);
            edges++;
            @(negedge clock);
        end
        chk32({tag, ".done_edge"}, edges, exp_edges);
        chk32({tag, ".result"}, bus.result, exp_res);
        chk32({tag, ".fflags"}, {27'd0, bus.fflags}, {27'd0, exp_fl});
        @(negedge clock);
        chk32({tag, ".done_pulse"}, {31'd0, bus.done}, 32'd0);
        chk32({tag, ".busy_after"}, {31'd0, bus.busy}, 32'd0);
        chk32({tag, ".held"}, bus.result, exp_res);
    endtask

    int edges;
    int done_seen;
    int busy_low;

    initial begin
        checks          = 0;
        failures        = 0;
        reset_n         = 1'b0;
        bus.start       = 1'b0;
        bus.is_unsigned = 1'b0;
        bus.rm          = 3'd0;
        bus.operand     = 32'd0;
        repeat (3) @(negedge clock);
        chk32("rst.busy", {31'd0, bus.busy}, 32'd0);
        chk32("rst.done", {31'd0, bus.done}, 32'd0);
        chk32("rst.result", bus.result, 32'd0);
        chk32("rst.fflags", {27'd0, bus.fflags}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        conv("pi_rne",    32'h40490FDB, 1'b0, 3'b000, 32'd3,        5'h01, 24);
        conv("m2p31",     32'hCF000000, 1'b0, 3'b001, 32'h80000000, 5'h00, 10);
        conv("p2p31",     32'h4F000000, 1'b0, 3'b000, 32'h7FFFFFFF, 5'h10, 10);
        conv("half_rne",  32'h3F000000, 1'b0, 3'b000, 32'd0,        5'h01, 26);
        conv("half_rup",  32'h3F000000, 1'b0, 3'b011, 32'd1,        5'h01, 26);
        conv("half_rmm",  32'h3F000000, 1'b0, 3'b100, 32'd1,        5'h01, 26);
        conv("half_rdn",  32'h3F000000, 1'b0, 3'b010, 32'd0,        5'h01, 26);
        conv("1p5_rne",   32'h3FC00000, 1'b0, 3'b000, 32'd2,        5'h01, 25);
        conv("2p5_rne",   32'h40200000, 1'b0, 3'b000, 32'd2,        5'h01, 24);
        conv("m2p5_rdn",  32'hC0200000, 1'b0, 3'b010, 32'hFFFFFFFD, 5'h01, 24);
        conv("rm7_rtz",   32'h3FC00000, 1'b0, 3'b111, 32'd1,        5'h01, 25);
        conv("u_nan",     32'h7FC00000, 1'b1, 3'b000, 32'hFFFFFFFF, 5'h10, 2);
        conv("u_m1",      32'hBF800000, 1'b1, 3'b000, 32'd0,        5'h10, 25);
        conv("u_mq_rtz",  32'hBE800000, 1'b1, 3'b001, 32'd0,        5'h01, 2);
        conv("u_max",     32'h4F7FFFFF, 1'b1, 3'b000, 32'hFFFFFF00, 5'h00, 10);
        conv("s_ninf",    32'hFF800000, 1'b0, 3'b000, 32'h80000000, 5'h10, 2);
        conv("s_zero",    32'h00000000, 1'b0, 3'b000, 32'd0,        5'h00, 2);

        // start held high: a second operand presented while busy is ignored
        @(negedge clock);
        bus.operand     = 32'h41200000;
        bus.is_unsigned = 1'b0;
        bus.rm          = 3'b000;
        bus.start       = 1'b1;
        @(posedge clock);
        edges    = 0;
        busy_low = 0;
        @(negedge clock);
        bus.operand = 32'h42C80000;
        bus.rm      = 3'b011;
        while (!bus.done && edges < 60) begin
            if (!bus.busy) busy_low++;
            @(posedge clock);
            edges++;
            @(negedge clock);
        end
        if (!bus.busy) busy_low++;
        bus.start = 1'b0;
        chk32("hold.busy_low", busy_low, 0);
        chk32("hold.edges", edges, 22);
        chk32("hold.result", bus.result, 32'd10);
        chk32("hold.fflags", {27'd0, bus.fflags}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        chk32("hold.no_second", {31'd0, bus.busy}, 32'd0);

        // reset during SHIFT aborts without a done pulse
        @(negedge clock);
        bus.operand   = 32'h40490FDB;
        bus.rm        = 3'b000;
        bus.start     = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (5) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk32("abort.busy", {31'd0, bus.busy}, 32'd0);
        chk32("abort.result", bus.result, 32'd0);
        chk32("abort.fflags", {27'd0, bus.fflags}, 32'd0);
        @(negedge clock);
        reset_n   = 1'b1;
        done_seen = 0;
        repeat (30) begin
            @(negedge clock);
            if (bus.done) done_seen++;
        end
        chk32("abort.no_done", done_seen, 0);

        conv("ten",       32'h41200000, 1'b0, 3'b000, 32'd10,       5'h00, 22);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
